fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage that drives the PC and feeds the execute stage. It supplies the current instruction, its PC, and PC+4 to execute. It consumes execute's next-PC (branch target or PC+4) as a redirect. It owns the PC register, a single-outstanding-request handshake to instruction memory, and a one-entry output buffer toward decode/execute.

Parameters:
RESET_PC, 64'h0, PC loaded on reset; must be 4-byte aligned.
XLEN, 64, PC/address width.
ILEN, 32, instruction width.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  imem accepts request this cycle.
imem_addr  output  XLEN  fetch address; bits [1:0] always 0.
imem_resp_valid  input  1  response data valid.
imem_resp_data  input  ILEN  fetched instruction word.
inst_valid  output  1  inst/pc_out/pc4 hold a valid instruction.
inst_ready  input  1  downstream consumes instruction this cycle.
inst  output  ILEN  instruction to decode/alu_control.
pc_out  output  XLEN  PC of inst; feeds branch-target adder.
pc4  output  XLEN  pc_out + 4, modulo 2^XLEN.
redirect_valid  input  1  execute supplies a non-sequential next PC.
redirect_pc  input  XLEN  target PC; execute's "in" value.
err_misaligned  output  1  sticky misaligned-redirect flag.

Behaviour:
- Reset: state=IDLE; fetch_pc=RESET_PC; all flags and outputs cleared.
  - imem_req_valid=0, inst_valid=0, inst=0, pc_out=0, pc4=0, err_misaligned=0.
  - Reset mid-operation discards any in-flight request.
  - A late imem_resp_valid arriving in IDLE/REQ/HOLD/HALT is ignored.
- States: IDLE, REQ, WAIT, HOLD, HALT. At most one outstanding imem request.
- IDLE: go to REQ next cycle unconditionally.
- REQ: imem_req_valid=1, imem_addr=fetch_pc.
  - On imem_req_ready: latch req_pc=fetch_pc, clear kill, go to WAIT.
  - A request is committed only on ready, so imem_addr may change while valid&!ready.
- WAIT: imem_req_valid=0.
  - On imem_resp_valid with kill=0: inst<=resp_data, pc_out<=req_pc, pc4<=req_pc+4, inst_valid<=1, go to HOLD.
  - On imem_resp_valid with kill=1: drop the data, go to REQ.
- HOLD: inst_valid=1; inst, pc_out and pc4 stay stable until consumed.
  - On inst_ready without redirect: fetch_pc<=pc4, inst_valid<=0, go to REQ.
- Redirect, checked every cycle, priority redirect > handshake:
  - Aligned target (redirect_pc[1:0]==0):
    - fetch_pc<=redirect_pc.
    - In WAIT: set kill; the pending response is discarded.
    - In HOLD: inst_valid<=0, go to REQ; this applies whether or not inst_ready is high.
    - In REQ: the new address is presented next cycle.
  - Misaligned target (redirect_pc[1:0]!=0): err_misaligned<=1, inst_valid<=0, go to HALT.
    - In WAIT, HALT is entered only after the pending response returns; the response is dropped.
  - Same-cycle redirect_valid && imem_resp_valid in WAIT: response dropped; the redirect target is the next request.
- HALT: no requests; stays until reset.
- Latency: with imem ready and a response one cycle later, a new inst_valid appears 2 cycles after entering REQ.
  - Sustained throughput: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Arithmetic: pc+4 wraps at 2^XLEN. 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
- Registered outputs: imem_req_valid, imem_addr, inst_valid, inst, pc_out, pc4, err_misaligned.

Decomposition:
- Shared package riscv_pkg:
  - fetch_state_t enum (IDLE, REQ, WAIT, HOLD, HALT).
  - XLEN, ILEN, PC_STEP=4, default RESET_PC.
- One sub-module, pc_incrementer: XLEN-bit combinational +4 adder, reused for fetch_pc and pc4.
- FSM and buffer registers stay in fetch_unit.

Test Plan:
- Reset, RESET_PC=0, imem_req_ready=1, response 1 cycle after accept with 32'h00000033 -> imem_addr=0 in cycle 1; cycle 3 inst_valid=1, inst=32'h00000033, pc_out=0, pc4=4.
- Backpressure: hold inst_ready=0 for 3 cycles in HOLD -> inst/pc_out stable, imem_req_valid=0. On inst_ready=1 -> next imem_addr=4.
- Redirect in HOLD: redirect_pc=64'h100 with inst_ready=1 -> inst_valid=0 next cycle, next imem_addr=64'h100, no request to address 4.
- Redirect in WAIT to 64'h200, then response 32'hDEADBEEF -> inst never valid with DEADBEEF; next imem_addr=64'h200. Repeat with redirect and response in the same cycle -> same result.
- Misaligned redirect 64'h102 -> err_misaligned=1, imem_req_valid stays 0 for 20 cycles. Reset clears it and fetch restarts at RESET_PC.
- Wrap: redirect to 64'hFFFF_FFFF_FFFF_FFFC, consume -> pc4=0, next imem_addr=0. Separately, assert reset during WAIT, then resp_valid in the next cycle -> response ignored, first post-reset fetch at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
package riscv_pkg;

  localparam int XLEN    = 64;
  localparam int ILEN    = 32;
  localparam int PC_STEP = 4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - imem, instruction and redirect signals of the fetch stage
interface fetch_unit_if #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int ILEN = riscv_pkg::ILEN
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc4;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            err_misaligned;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, pc_out, pc4, err_misaligned,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, pc_out, pc4, err_misaligned,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_unit_pc_incrementer.sv
// rtl/fetch_unit_pc_incrementer.sv - combinational PC + 4, wrapping at 2^W
module pc_incrementer
  import riscv_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] pc_in,
  output logic [W-1:0] pc_next
);

  assign pc_next = pc_in + W'(PC_STEP);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, single-outstanding imem fetch and one-entry output buffer
module fetch_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              ILEN     = riscv_pkg::ILEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::DEFAULT_RESET_PC)
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  import riscv_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            kill_q, kill_d;
  logic            halt_pend_q, halt_pend_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            inst_valid_q, inst_valid_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] req_pc_plus4;
  logic            redir_ok;
  logic            redir_bad;

  pc_incrementer #(.W(XLEN)) u_pc_inc (
    .pc_in   (req_pc_q),
    .pc_next (req_pc_plus4)
  );

  assign redir_ok  = bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
  assign redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    kill_d       = kill_q;
    halt_pend_d  = halt_pend_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    pc_out_d     = pc_out_q;
    pc4_d        = pc4_q;
    err_d        = err_q;

    unique case (state_q)
      IDLE: begin
        if (redir_bad) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          if (redir_ok) fetch_pc_d = bus.redirect_pc;
          state_d = REQ;
        end
      end

      REQ: begin
        // A request seen with ready is already owned by imem even if a redirect
        // wins, so it is committed and its response is killed instead.
        if (redir_bad) begin
          err_d        = 1'b1;
          inst_valid_d = 1'b0;
          if (bus.imem_req_ready) begin
            req_pc_d    = fetch_pc_q;
            kill_d      = 1'b1;
            halt_pend_d = 1'b1;
            state_d     = WAIT;
          end else begin
            state_d = HALT;
          end
        end else if (redir_ok) begin
          fetch_pc_d = bus.redirect_pc;
          if (bus.imem_req_ready) begin
            req_pc_d = fetch_pc_q;
            kill_d   = 1'b1;
            state_d  = WAIT;
          end
        end else if (bus.imem_req_ready) begin
          req_pc_d    = fetch_pc_q;
          kill_d      = 1'b0;
          halt_pend_d = 1'b0;
          state_d     = WAIT;
        end
      end

      WAIT: begin
        if (redir_bad) begin
          err_d        = 1'b1;
          inst_valid_d = 1'b0;
          halt_pend_d  = 1'b1;
          kill_d       = 1'b1;
        end else if (redir_ok) begin
          fetch_pc_d = bus.redirect_pc;
          kill_d     = 1'b1;
        end
        if (bus.imem_resp_valid) begin
          if (redir_bad || halt_pend_q) begin
            state_d = HALT;
          end else if (redir_ok || kill_q) begin
            state_d = REQ;
          end else begin
            inst_d       = bus.imem_resp_data;
            pc_out_d     = req_pc_q;
            pc4_d        = req_pc_plus4;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end
      end

      HOLD: begin
        if (redir_bad) begin
          err_d        = 1'b1;
          inst_valid_d = 1'b0;
          state_d      = HALT;
        end else if (redir_ok) begin
          fetch_pc_d   = bus.redirect_pc;
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end else if (bus.inst_ready) begin
          fetch_pc_d   = pc4_q;
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end

      HALT: state_d = HALT;

      default: state_d = IDLE;
    endcase

    // Request outputs are registered, so they follow the state being entered.
    req_valid_d = (state_d == REQ);
    addr_d      = (state_d == REQ) ? fetch_pc_d : addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= '0;
      kill_q       <= 1'b0;
      halt_pend_q  <= 1'b0;
      req_valid_q  <= 1'b0;
      addr_q       <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      pc_out_q     <= '0;
      pc4_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      kill_q       <= kill_d;
      halt_pend_q  <= halt_pend_d;
      req_valid_q  <= req_valid_d;
      addr_q       <= addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      pc_out_q     <= pc_out_d;
      pc4_q        <= pc4_d;
      err_q        <= err_d;
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_addr      = addr_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.pc_out         = pc_out_q;
  assign bus.pc4            = pc4_q;
  assign bus.err_misaligned = err_q;

endmodule
